// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter that merges NUM_SRC AXI-stream sources into
// one sink. Ownership is granted per packet and held until the owner's last
// beat transfers; per-source completed-packet counters saturate at 16'hFFFF.
module axis_packet_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_BYTES = 1,
    parameter int unsigned DATA_BITS  = DATA_BYTES * 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_SRC*DATA_BITS-1:0]   axis_s_data_i,
    input  logic [NUM_SRC-1:0]             axis_s_valid_i,
    output logic [NUM_SRC-1:0]             axis_s_ready_o,
    input  logic [NUM_SRC-1:0]             axis_s_last_i,
    output logic [DATA_BITS-1:0]           axis_m_data_o,
    output logic                           axis_m_valid_o,
    input  logic                           axis_m_ready_i,
    output logic                           axis_m_last_o,
    output logic [NUM_SRC-1:0]             grant_o,
    output logic                           pkt_done_o,
    output logic [NUM_SRC*16-1:0]          pkt_count_o
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [NUM_SRC-1:0]     grant_q;
    logic                   pkt_done_q;
    logic [NUM_SRC*16-1:0]  pkt_cnt_q;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic                   busy;
    logic                   last_xfer;
    logic [15:0]            owner_cnt;

    // Find the first valid source at or after rr_ptr, wrapping modulo NUM_SRC
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = i + 32'(rr_ptr_q);
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!pick_found && axis_s_valid_i[IDX_W'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
    end

    // Route the owner's stream to the sink; everything is quiet while IDLE
    always_comb begin
        busy           = (state_q == BUSY);
        axis_m_valid_o = busy & axis_s_valid_i[owner_q];
        axis_m_last_o  = busy & axis_s_last_i[owner_q];
        axis_m_data_o  = busy ? axis_s_data_i[owner_q*DATA_BITS +: DATA_BITS] : '0;
        // grant_q is all-zero in IDLE, so this also forces ready low there
        axis_s_ready_o = grant_q & {NUM_SRC{axis_m_ready_i}};
        last_xfer      = axis_m_valid_o & axis_m_ready_i & axis_m_last_o;
        owner_cnt      = pkt_cnt_q[owner_q*16 +: 16];
    end

    // Arbitration FSM, round-robin pointer, packet counters and done pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            pkt_done_q <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            pkt_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        owner_q <= pick_idx;
                        grant_q <= NUM_SRC'(1) << pick_idx;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (last_xfer) begin
                        state_q    <= IDLE;
                        grant_q    <= '0;
                        rr_ptr_q   <= (owner_q == IDX_W'(NUM_SRC - 1)) ? '0 : owner_q + 1'b1;
                        pkt_done_q <= 1'b1;
                        if (owner_cnt != 16'hFFFF) begin
                            pkt_cnt_q[owner_q*16 +: 16] <= owner_cnt + 16'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign pkt_done_o  = pkt_done_q;
    assign pkt_count_o = pkt_cnt_q;

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of AXI-stream sources; legal range 2..8.
REQ-002 SHALL have parameter DATA_BYTES, default 1, bytes per beat on every stream.
REQ-003 SHALL have parameter DATA_BITS, default DATA_BYTES*8, beat width in bits.
REQ-004 SHALL have port clk_i input 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i input 1: reset, synchronous, active-high.
REQ-006 SHALL have port axis_s_data_i input NUM_SRC*DATA_BITS: source data; source k occupies bits [k*DATA_BITS +: DATA_BITS].
REQ-007 SHALL have port axis_s_valid_i input NUM_SRC: per-source valid.
REQ-008 SHALL have port axis_s_ready_o output NUM_SRC: per-source ready.
REQ-009 SHALL have port axis_s_last_i input NUM_SRC: per-source end-of-packet.
REQ-010 SHALL have port axis_m_data_o output DATA_BITS: merged data.
REQ-011 SHALL have port axis_m_valid_o output 1: merged valid.
REQ-012 SHALL have port axis_m_ready_i input 1: sink ready.
REQ-013 SHALL have port axis_m_last_o output 1: merged end-of-packet.
REQ-014 SHALL have port grant_o output NUM_SRC: one-hot current owner, all-zero when idle.
REQ-015 SHALL have port pkt_done_o output 1: one-cycle pulse per completed packet.
REQ-016 SHALL have port pkt_count_o output NUM_SRC*16: per-source completed-packet counters; source k at [k*16 +: 16].

Function
REQ-017 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-018 In IDLE, axis_s_ready_o, axis_m_valid_o, axis_m_last_o SHALL be 0, and grant_o SHALL be all-zero.
REQ-019 In IDLE with any axis_s_valid_i set, SHALL select the first valid source at or after rr_ptr, searching upward modulo NUM_SRC; register it as owner; enter BUSY next cycle.
REQ-020 Arbitration latency SHALL be exactly 1 cycle: the owner's first beat can transfer no earlier than the cycle after the request is seen in IDLE.
REQ-021 In BUSY, axis_m_data_o, axis_m_valid_o and axis_m_last_o SHALL combinationally follow the owner's data, valid and last.
REQ-022 In BUSY, axis_s_ready_o[owner] SHALL equal axis_m_ready_i; all other ready bits SHALL be 0.
REQ-023 A beat SHALL transfer when axis_m_valid_o && axis_m_ready_i.
REQ-024 Ownership SHALL hold through owner valid gaps and sink back-pressure; no re-arbitration until a last beat transfers.
REQ-025 On transfer of a beat with last=1, all of the following SHALL occur next cycle:
 - FSM returns to IDLE.
 - rr_ptr = (owner+1) mod NUM_SRC.
 - pkt_count[owner] increments.
 - pkt_done_o pulses high for exactly 1 cycle.
REQ-026 pkt_count SHALL saturate at 16'hFFFF (no wrap).
REQ-027 Between consecutive packets there SHALL be at least one IDLE cycle; maximum sustained throughput is L/(L+1) beats/cycle for L-beat packets.
REQ-028 A single-beat packet (valid and last on its first beat) SHALL be accepted and counted like any other packet.
REQ-029 Valid and last from non-owner sources SHALL be ignored while BUSY; a non-owner holding valid SHALL stall with no data loss.
REQ-030 With all sources continuously valid, grant order SHALL be 0,1,...,NUM_SRC-1,0,...; no source waits more than NUM_SRC-1 packets.
REQ-031 Outputs SHALL be free of X whenever rst_i is low and all inputs are known.

Reset
REQ-032 While rst_i=1 at a clock edge, the block SHALL load: state IDLE, owner 0, rr_ptr 0, all pkt_count 0, pkt_done_o 0, grant_o 0.
REQ-033 Assertion of rst_i mid-packet SHALL abandon the packet: no count increment, no pkt_done_o, and axis_s_ready_o all 0 from the next cycle.
REQ-034 The first arbitration after reset deassertion SHALL start from rr_ptr 0.

Verification
REQ-035 Single source: src2 sends a 3-beat packet (data 0x11, 0x22, 0x33, last on 0x33) with sink ready -> grant_o=4'b0100 one cycle after valid; three consecutive output beats; pkt_done_o one pulse; pkt_count[2]=1.
REQ-036 All four sources valid with 2-beat packets, sink always ready -> grant sequence 0,1,2,3,0; each grant lasts 2 cycles followed by 1 idle cycle.
REQ-037 Back-pressure: axis_m_ready_i low for 5 cycles mid-packet -> owner's ready low; output data held stable; other sources' ready stays 0; no beat dropped or duplicated.
REQ-038 Owner valid gap: src1 deasserts valid for 3 cycles mid-packet while src0 is valid -> grant stays with src1; src0 is granted only after src1's last beat.
REQ-039 Counter saturation: force pkt_count[0] to 16'hFFFE, then send 3 packets from src0 -> counter reads 16'hFFFF and stays there.
REQ-040 Reset mid-packet: assert rst_i after beat 2 of a 4-beat src3 packet -> pkt_count[3]=0, grant_o=0; next arbitration with src1 and src3 valid grants src1 first.
